// File: rtl/req_enc_pkg.sv
// Shared definitions for the round-robin request encoder.
package req_enc_pkg;

  localparam int unsigned N_DEF = 4;

  // Width of a binary index able to address n sources.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_t;

endpackage : req_enc_pkg

// File: rtl/req_encoder_rr_pick.sv
// Round-robin picker: first set bit of cand scanning from ptr upward, modulo N.
module rr_pick
  import req_enc_pkg::*;
#(
  parameter  int unsigned N = N_DEF,
  localparam int unsigned W = idx_w(N)
) (
  input  logic [N-1:0] cand,
  input  logic [W-1:0] ptr,
  output logic         any,
  output logic [W-1:0] sel,
  output logic [N-1:0] onehot
);

  logic [N-1:0] w_rot;
  logic [W-1:0] w_src;
  logic [W-1:0] w_idx;
  logic         w_found;

  // Rotate right by ptr, fixed-priority LSB pick, then map back by adding ptr.
  always_comb begin
    w_rot   = '0;
    w_src   = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      w_src    = W'(i) + ptr;
      w_rot[i] = cand[w_src];
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!w_found && w_rot[i]) begin
        w_idx   = W'(i);
        w_found = 1'b1;
      end
    end
    any    = w_found;
    sel    = w_idx + ptr;
    onehot = w_found ? (N'(1) << sel) : '0;
  end

endmodule : rr_pick

// File: rtl/req_encoder_rr.sv
// Captures request lines into sticky pending bits and hands out one binary
// index per grant, round-robin fair, over a valid/ready output slot.
module req_encoder_rr
  import req_enc_pkg::*;
#(
  parameter  int unsigned N = N_DEF,
  localparam int unsigned W = idx_w(N)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic [N-1:0] req_i,
  output logic [W-1:0] code_o,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [N-1:0] pend_o,
  output logic         drop_o
);

  slot_t        r_state;
  slot_t        w_state_nxt;
  logic [N-1:0] r_pend;
  logic [W-1:0] r_ptr;
  logic [W-1:0] r_code;
  logic         r_drop;

  logic [N-1:0] w_cap;
  logic [N-1:0] w_cand;
  logic         w_load;
  logic         w_any;
  logic [W-1:0] w_sel;
  logic [N-1:0] w_onehot;
  logic [N-1:0] w_gmask;
  logic [N-1:0] w_pend_nxt;
  logic         w_drop_nxt;

  rr_pick #(
    .N(N)
  ) u_pick (
    .cand  (w_cand),
    .ptr   (r_ptr),
    .any   (w_any),
    .sel   (w_sel),
    .onehot(w_onehot)
  );

  // Capture, grant mask, pending update and slot next state.
  always_comb begin
    w_cap       = req_i & {N{en_i}};
    w_cand      = r_pend | w_cap;
    w_load      = (r_state == EMPTY) || ready_i;
    w_gmask     = (w_load && w_any) ? w_onehot : '0;
    // A bit that was already pending and is re-requested while being granted
    // stays set; a fresh request that is granted immediately is consumed.
    w_pend_nxt  = (w_cand & ~w_gmask) | (w_cap & r_pend);
    w_drop_nxt  = |(w_cap & r_pend & ~w_gmask);
    w_state_nxt = r_state;
    if (w_load) begin
      w_state_nxt = w_any ? FULL : EMPTY;
    end
  end

  // Output slot state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Pending bits, rotation pointer, held code and drop pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pend <= '0;
      r_ptr  <= '0;
      r_code <= '0;
      r_drop <= 1'b0;
    end else begin
      r_pend <= w_pend_nxt;
      r_drop <= w_drop_nxt;
      if (w_load && w_any) begin
        r_code <= w_sel;
        r_ptr  <= w_sel + W'(1);
      end
    end
  end

  assign code_o  = r_code;
  assign valid_o = (r_state == FULL);
  assign pend_o  = r_pend;
  assign drop_o  = r_drop;

endmodule : req_encoder_rr

// File: tb/tb_req_encoder_rr.sv
// Directed bench for req_encoder_rr (N=4): vector table plus reset sequences.
module tb_req_encoder_rr;

  typedef struct {
    logic       en;
    logic [3:0] req;
    logic       rdy;
    logic       ev;
    logic [1:0] ec;
    logic [3:0] ep;
    logic       ed;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] req;
  logic       rdy;
  logic [1:0] code;
  logic       valid;
  logic [3:0] pend;
  logic       drop;

  int unsigned n_chk;
  int unsigned n_pass;

  vec_t tv[$];

  req_encoder_rr #(
    .N(4)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .en_i   (en),
    .req_i  (req),
    .code_o (code),
    .valid_o(valid),
    .ready_i(rdy),
    .pend_o (pend),
    .drop_o (drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic e, input logic [3:0] r, input logic y,
                              input logic v, input logic [1:0] c, input logic [3:0] p,
                              input logic d);
    vec_t t;
    t.en = e; t.req = r; t.rdy = y; t.ev = v; t.ec = c; t.ep = p; t.ed = d;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_all(input string tag, input logic v, input logic [1:0] c,
                           input logic [3:0] p, input logic d);
    check({tag, ".valid"}, 32'(valid), 32'(v));
    check({tag, ".code"},  32'(code),  32'(c));
    check({tag, ".pend"},  32'(pend),  32'(p));
    check({tag, ".drop"},  32'(drop),  32'(d));
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;

    // en, req, ready | valid, code, pend, drop (state after the edge)
    // round robin draining 1110 from ptr=1
    tv.push_back(mk(1, 4'b0000, 1, 1, 2'd1, 4'b1100, 0));
    tv.push_back(mk(1, 4'b0000, 1, 1, 2'd2, 4'b1000, 0));
    tv.push_back(mk(1, 4'b0000, 1, 1, 2'd3, 4'b0000, 0));
    tv.push_back(mk(1, 4'b0000, 1, 0, 2'd3, 4'b0000, 0));
    // backpressure: grant 2 held for 5 cycles, then one handshake
    tv.push_back(mk(1, 4'b0100, 0, 1, 2'd2, 4'b0000, 0));
    tv.push_back(mk(1, 4'b0000, 0, 1, 2'd2, 4'b0000, 0));
    tv.push_back(mk(1, 4'b0000, 0, 1, 2'd2, 4'b0000, 0));
    tv.push_back(mk(1, 4'b0000, 0, 1, 2'd2, 4'b0000, 0));
    tv.push_back(mk(1, 4'b0000, 0, 1, 2'd2, 4'b0000, 0));
    tv.push_back(mk(1, 4'b0000, 0, 1, 2'd2, 4'b0000, 0));
    tv.push_back(mk(1, 4'b0000, 1, 0, 2'd2, 4'b0000, 0));
    // wrap: ptr=3, request 1001 -> 3 then 0
    tv.push_back(mk(1, 4'b1001, 1, 1, 2'd3, 4'b0001, 0));
    tv.push_back(mk(1, 4'b0000, 1, 1, 2'd0, 4'b0000, 0));
    tv.push_back(mk(1, 4'b0000, 1, 0, 2'd0, 4'b0000, 0));
    // drop and set-wins (ptr=1 here)
    tv.push_back(mk(1, 4'b0100, 0, 1, 2'd2, 4'b0000, 0));
    tv.push_back(mk(1, 4'b0010, 0, 1, 2'd2, 4'b0010, 0));
    tv.push_back(mk(1, 4'b0010, 0, 1, 2'd2, 4'b0010, 1));
    tv.push_back(mk(1, 4'b0000, 0, 1, 2'd2, 4'b0010, 0));
    tv.push_back(mk(1, 4'b0010, 1, 1, 2'd1, 4'b0010, 0));
    tv.push_back(mk(1, 4'b0000, 1, 1, 2'd1, 4'b0000, 0));
    tv.push_back(mk(1, 4'b0000, 1, 0, 2'd1, 4'b0000, 0));
    // enable low: requests ignored, pending still drains
    tv.push_back(mk(0, 4'b1111, 1, 0, 2'd1, 4'b0000, 0));
    tv.push_back(mk(0, 4'b1111, 1, 0, 2'd1, 4'b0000, 0));
    tv.push_back(mk(1, 4'b0001, 0, 1, 2'd0, 4'b0000, 0));
    tv.push_back(mk(1, 4'b0110, 0, 1, 2'd0, 4'b0110, 0));
    tv.push_back(mk(0, 4'b1111, 0, 1, 2'd0, 4'b0110, 0));
    tv.push_back(mk(0, 4'b1111, 1, 1, 2'd1, 4'b0100, 0));

    // Reset held with all requests active
    rst_n = 1'b0;
    en    = 1'b1;
    req   = 4'b1111;
    rdy   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 1'b0, 2'd0, 4'b0000, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all("release", 1'b1, 2'd0, 4'b1110, 1'b0);

    for (int i = 0; i < tv.size(); i++) begin
      en  = tv[i].en;
      req = tv[i].req;
      rdy = tv[i].rdy;
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), tv[i].ev, tv[i].ec, tv[i].ep, tv[i].ed);
    end

    // Async reset while FULL with pending bits: clears without a clock edge
    en  = 1'b0;
    req = 4'b0000;
    rdy = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 1'b0, 2'd0, 4'b0000, 1'b0);
    @(posedge clk);
    #1;
    check_all("rst_hold", 1'b0, 2'd0, 4'b0000, 1'b0);

    // After release, pointer restarts at 0
    rst_n = 1'b1;
    en    = 1'b1;
    req   = 4'b1010;
    rdy   = 1'b1;
    @(posedge clk);
    #1;
    check_all("post_rst", 1'b1, 2'd1, 4'b1000, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_req_encoder_rr
